// File: rtl/pulse_seq_pkg.sv
// Shared types for the pulse sequencer: FSM state encoding.
package pulse_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } pulse_seq_state_t;

endpackage

// File: rtl/pulse_generator.sv
// Free-running tick counter: out_o fires for one cycle every ticks_i+1 enabled cycles.
// The first pulse after reset arrives on the ticks_i-th enabled cycle (0-based).
module pulse_generator #(
  parameter int N = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         ena_i,
  input  logic [N-1:0] ticks_i,
  output logic         out_o
);

  logic [N-1:0] cnt_q, cnt_d;

  assign out_o = ena_i && (cnt_q == ticks_i);

  always_comb begin
    cnt_d = cnt_q;
    if (ena_i) begin
      cnt_d = out_o ? '0 : cnt_q + N'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pulse_sequencer.sv
// Steps one pulse_generator through a (period, repeat) table, optionally looping.
// start -> LOAD next cycle -> RUN; each entry change costs one LOAD cycle; stop aborts.
module pulse_sequencer
  import pulse_seq_pkg::*;
#(
  parameter  int N     = 8,
  parameter  int C     = 4,
  parameter  int DEPTH = 4,
  localparam int A     = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         wr_en_i,
  input  logic [A-1:0] wr_addr_i,
  input  logic [N-1:0] wr_ticks_i,
  input  logic [C-1:0] wr_reps_i,
  input  logic [A-1:0] last_idx_i,
  input  logic         loop_i,
  input  logic         start_i,
  input  logic         stop_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         pulse_o,
  output logic [A-1:0] idx_o
);

  pulse_seq_state_t state_q, state_d;
  logic [A-1:0] idx_q, idx_d, last_q, last_d;
  logic         loop_q, loop_d;
  logic [N-1:0] cur_ticks_q, cur_ticks_d;
  logic [C-1:0] rep_left_q, rep_left_d;
  logic [N-1:0] tbl_ticks_q [DEPTH];
  logic [C-1:0] tbl_reps_q  [DEPTH];
  logic         gen_rst, gen_ena, gen_out, entry_end, seq_end;

  assign gen_ena   = (state_q == S_RUN);
  assign gen_rst   = rst_i || !gen_ena;
  assign entry_end = gen_ena && gen_out && (rep_left_q == C'(1));
  assign seq_end   = (idx_q == last_q) && !loop_q;

  pulse_generator #(.N(N)) u_gen (
    .clk_i   (clk_i),
    .rst_i   (gen_rst),
    .ena_i   (gen_ena),
    .ticks_i (cur_ticks_q),
    .out_o   (gen_out)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (stop_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start_i) state_d = S_LOAD;
        S_LOAD:  state_d = S_RUN;
        S_RUN:   if (entry_end) state_d = seq_end ? S_DONE : S_LOAD;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o  = (state_q == S_LOAD) || (state_q == S_RUN);
    done_o  = (state_q == S_DONE);
    pulse_o = gen_ena && gen_out;
    idx_o   = idx_q;
  end

  // A zero repeat count still plays the entry once.
  always_comb begin
    idx_d       = idx_q;
    last_d      = last_q;
    loop_d      = loop_q;
    cur_ticks_d = cur_ticks_q;
    rep_left_d  = rep_left_q;
    if (!stop_i) begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            idx_d  = '0;
            last_d = last_idx_i;
            loop_d = loop_i;
          end
        end
        S_LOAD: begin
          cur_ticks_d = tbl_ticks_q[idx_q];
          rep_left_d  = (tbl_reps_q[idx_q] == '0) ? C'(1) : tbl_reps_q[idx_q];
        end
        S_RUN: begin
          if (gen_out) begin
            rep_left_d = rep_left_q - C'(1);
            if (entry_end && !seq_end) begin
              idx_d = (idx_q == last_q) ? '0 : idx_q + A'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q       <= '0;
      last_q      <= '0;
      loop_q      <= 1'b0;
      cur_ticks_q <= '0;
      rep_left_q  <= '0;
    end else begin
      idx_q       <= idx_d;
      last_q      <= last_d;
      loop_q      <= loop_d;
      cur_ticks_q <= cur_ticks_d;
      rep_left_q  <= rep_left_d;
    end
  end

  // Writes land at the clock edge, so a LOAD reading the same entry sees the old value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_ticks_q[i] <= '0;
        tbl_reps_q[i]  <= '0;
      end
    end else if (wr_en_i) begin
      tbl_ticks_q[wr_addr_i] <= wr_ticks_i;
      tbl_reps_q[wr_addr_i]  <= wr_reps_i;
    end
  end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Bench for pulse_sequencer: directed scenarios plus randomized tables against a schedule model.
module tb_pulse_sequencer;

  localparam int H = 256;

  logic       clk = 1'b0;
  logic       rst_i, wr_en_i, loop_i, start_i, stop_i;
  logic [1:0] wr_addr_i, last_idx_i, idx_o;
  logic [7:0] wr_ticks_i;
  logic [3:0] wr_reps_i;
  logic       busy_o, done_o, pulse_o;

  int m_ticks[4];
  int m_reps[4];
  bit eb[H];
  bit ep[H];
  bit ed[H];
  bit xs[H];
  int ei[H];
  int fin;
  int n_cmp = 0;
  int n_bad = 0;

  pulse_sequencer dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .wr_ticks_i (wr_ticks_i),
    .wr_reps_i  (wr_reps_i),
    .last_idx_i (last_idx_i),
    .loop_i     (loop_i),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .pulse_o    (pulse_o),
    .idx_o      (idx_o)
  );

  always #5 clk = ~clk;

  // Expected per-cycle outputs, cycle 0 = the cycle start is asserted.
  // Each entry: one LOAD cycle, then reps*(T+1) RUN cycles with a pulse at the end of each period.
  task automatic model(input int last, input bit lp);
    int c, e, r, t;
    for (int i = 0; i < H; i++) begin
      eb[i] = 0; ep[i] = 0; ed[i] = 0; xs[i] = 0; ei[i] = 0;
    end
    c = 1; e = 0; fin = H;
    while (c < H) begin
      eb[c] = 1; ei[c] = e; c++;
      t = m_ticks[e];
      r = (m_reps[e] == 0) ? 1 : m_reps[e];
      for (int k = 0; k < r * (t + 1) && c < H; k++) begin
        eb[c] = 1; ei[c] = e; ep[c] = ((k % (t + 1)) == t); c++;
      end
      if (e != last) e++;
      else if (lp) e = 0;
      else begin
        if (c < H) ed[c] = 1;
        fin = c;
        break;
      end
    end
  endtask

  task automatic cut_after(input int s);
    for (int i = s + 1; i < H; i++) begin
      eb[i] = 0; ep[i] = 0; ed[i] = 0;
    end
  endtask

  task automatic wr(input int a, input int t, input int r);
    wr_en_i = 1'b1; wr_addr_i = 2'(a); wr_ticks_i = 8'(t); wr_reps_i = 4'(r);
    @(posedge clk); #1;
    wr_en_i = 1'b0;
    m_ticks[a] = t; m_reps[a] = r;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    n_cmp += 4;
    if (busy_o !== 1'b0)  begin n_bad++; $display("FAIL reset busy got %b want 0", busy_o); end
    if (done_o !== 1'b0)  begin n_bad++; $display("FAIL reset done got %b want 0", done_o); end
    if (pulse_o !== 1'b0) begin n_bad++; $display("FAIL reset pulse got %b want 0", pulse_o); end
    if (idx_o !== 2'd0)   begin n_bad++; $display("FAIL reset idx got %0d want 0", idx_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    int len;
    wr(0, 2, 3);
    last_idx_i = 2'd0; loop_i = 1'b0;
    model(0, 0);
    len = fin + 2;
    for (int c = 0; c < len; c++) begin
      start_i = (c == 0);
      @(negedge clk);
      n_cmp += 3;
      if (busy_o !== eb[c])  begin n_bad++; $display("FAIL single busy c=%0d got %b want %b", c, busy_o, eb[c]); end
      if (pulse_o !== ep[c]) begin n_bad++; $display("FAIL single pulse c=%0d got %b want %b", c, pulse_o, ep[c]); end
      if (done_o !== ed[c])  begin n_bad++; $display("FAIL single done c=%0d got %b want %b", c, done_o, ed[c]); end
      @(posedge clk); #1;
    end
    start_i = 1'b0;
  endtask

  task automatic test_two_entry;
    int len;
    wr(0, 2, 1);
    wr(1, 0, 2);
    last_idx_i = 2'd1; loop_i = 1'b0;
    model(1, 0);
    len = fin + 2;
    for (int c = 0; c < len; c++) begin
      start_i = (c == 0);
      @(negedge clk);
      n_cmp += 3;
      if (busy_o !== eb[c])  begin n_bad++; $display("FAIL two busy c=%0d got %b want %b", c, busy_o, eb[c]); end
      if (pulse_o !== ep[c]) begin n_bad++; $display("FAIL two pulse c=%0d got %b want %b", c, pulse_o, ep[c]); end
      if (done_o !== ed[c])  begin n_bad++; $display("FAIL two done c=%0d got %b want %b", c, done_o, ed[c]); end
      if (eb[c]) begin
        n_cmp++;
        if (idx_o !== ei[c][1:0]) begin n_bad++; $display("FAIL two idx c=%0d got %0d want %0d", c, idx_o, ei[c]); end
      end
      @(posedge clk); #1;
    end
    start_i = 1'b0;
  endtask

  task automatic test_loop_stop;
    int len, s;
    wr(0, 1, 1);
    last_idx_i = 2'd0; loop_i = 1'b1;
    model(0, 1);
    s = 20;
    cut_after(s);
    len = s + 4;
    for (int c = 0; c < len; c++) begin
      start_i = (c == 0); stop_i = (c == s);
      @(negedge clk);
      n_cmp += 3;
      if (busy_o !== eb[c])  begin n_bad++; $display("FAIL loop busy c=%0d got %b want %b", c, busy_o, eb[c]); end
      if (pulse_o !== ep[c]) begin n_bad++; $display("FAIL loop pulse c=%0d got %b want %b", c, pulse_o, ep[c]); end
      if (done_o !== ed[c])  begin n_bad++; $display("FAIL loop done c=%0d got %b want %b", c, done_o, ed[c]); end
      @(posedge clk); #1;
    end
    start_i = 1'b0; stop_i = 1'b0; loop_i = 1'b0;
  endtask

  // Run 0: stop mid-RUN at cycle 6; run 1: full restart. Run 2: start&stop together in IDLE.
  task automatic test_stop_restart;
    int len, s;
    wr(0, 2, 3);
    last_idx_i = 2'd0; loop_i = 1'b0;
    for (int run = 0; run < 3; run++) begin
      model(0, 0);
      s = (run == 0) ? 6 : (run == 2) ? 0 : -1;
      if (s >= 0) cut_after(s);
      len = (s >= 0) ? s + 5 : fin + 2;
      for (int c = 0; c < len; c++) begin
        start_i = (c == 0); stop_i = (c == s);
        @(negedge clk);
        n_cmp += 3;
        if (busy_o !== eb[c])  begin n_bad++; $display("FAIL stop%0d busy c=%0d got %b want %b", run, c, busy_o, eb[c]); end
        if (pulse_o !== ep[c]) begin n_bad++; $display("FAIL stop%0d pulse c=%0d got %b want %b", run, c, pulse_o, ep[c]); end
        if (done_o !== ed[c])  begin n_bad++; $display("FAIL stop%0d done c=%0d got %b want %b", run, c, done_o, ed[c]); end
        @(posedge clk); #1;
      end
      start_i = 1'b0; stop_i = 1'b0;
    end
  endtask

  task automatic test_start_while_busy;
    int len;
    wr(0, 2, 3);
    last_idx_i = 2'd0; loop_i = 1'b0;
    model(0, 0);
    xs[3] = 1; xs[5] = 1; xs[fin] = 1;
    len = fin + 3;
    for (int c = 0; c < len; c++) begin
      start_i = (c == 0) || xs[c];
      @(negedge clk);
      n_cmp += 3;
      if (busy_o !== eb[c])  begin n_bad++; $display("FAIL busystart busy c=%0d got %b want %b", c, busy_o, eb[c]); end
      if (pulse_o !== ep[c]) begin n_bad++; $display("FAIL busystart pulse c=%0d got %b want %b", c, pulse_o, ep[c]); end
      if (done_o !== ed[c])  begin n_bad++; $display("FAIL busystart done c=%0d got %b want %b", c, done_o, ed[c]); end
      @(posedge clk); #1;
    end
    start_i = 1'b0;
  endtask

  // Run 0 writes entry 0 during its own LOAD (old value used); run 1 then plays the new value.
  task automatic test_write_during_load;
    int len;
    wr(0, 3, 2);
    last_idx_i = 2'd0; loop_i = 1'b0;
    for (int run = 0; run < 2; run++) begin
      model(0, 0);
      len = fin + 2;
      for (int c = 0; c < len; c++) begin
        start_i = (c == 0);
        wr_en_i = (run == 0) && (c == 1);
        wr_addr_i = 2'd0; wr_ticks_i = 8'd0; wr_reps_i = 4'd1;
        @(negedge clk);
        n_cmp += 3;
        if (busy_o !== eb[c])  begin n_bad++; $display("FAIL wrload%0d busy c=%0d got %b want %b", run, c, busy_o, eb[c]); end
        if (pulse_o !== ep[c]) begin n_bad++; $display("FAIL wrload%0d pulse c=%0d got %b want %b", run, c, pulse_o, ep[c]); end
        if (done_o !== ed[c])  begin n_bad++; $display("FAIL wrload%0d done c=%0d got %b want %b", run, c, done_o, ed[c]); end
        @(posedge clk); #1;
      end
      start_i = 1'b0; wr_en_i = 1'b0;
      m_ticks[0] = 0; m_reps[0] = 1;
    end
  endtask

  // Run 0 is hit by rst at cycle 5; run 1 then plays the cleared table (ticks 0, reps 0 -> 1 pulse).
  task automatic test_reps0_reset;
    int len, s;
    wr(0, 2, 3);
    last_idx_i = 2'd0; loop_i = 1'b0;
    for (int run = 0; run < 2; run++) begin
      model(0, 0);
      s = (run == 0) ? 5 : -1;
      if (s >= 0) cut_after(s);
      len = (s >= 0) ? s + 4 : fin + 2;
      for (int c = 0; c < len; c++) begin
        start_i = (c == 0); rst_i = (c == s);
        @(negedge clk);
        n_cmp += 3;
        if (busy_o !== eb[c])  begin n_bad++; $display("FAIL rst%0d busy c=%0d got %b want %b", run, c, busy_o, eb[c]); end
        if (pulse_o !== ep[c]) begin n_bad++; $display("FAIL rst%0d pulse c=%0d got %b want %b", run, c, pulse_o, ep[c]); end
        if (done_o !== ed[c])  begin n_bad++; $display("FAIL rst%0d done c=%0d got %b want %b", run, c, done_o, ed[c]); end
        if (run == 0 && c == s + 1) begin
          n_cmp++;
          if (idx_o !== 2'd0) begin n_bad++; $display("FAIL rst idx got %0d want 0", idx_o); end
        end
        @(posedge clk); #1;
      end
      start_i = 1'b0; rst_i = 1'b0;
      for (int a = 0; a < 4; a++) begin m_ticks[a] = 0; m_reps[a] = 0; end
    end
  endtask

  task automatic test_random;
    int last, s, len;
    bit lp;
    for (int it = 0; it < 30; it++) begin
      for (int a = 0; a < 4; a++) wr(a, int'($urandom_range(0, 7)), int'($urandom_range(0, 5)));
      last = int'($urandom_range(0, 3));
      lp = ($urandom_range(0, 3) == 0);
      last_idx_i = 2'(last); loop_i = lp;
      model(last, lp);
      s = -1;
      if (lp) s = int'($urandom_range(3, 120));
      else if ($urandom_range(0, 2) == 0) s = int'($urandom_range(0, fin));
      if (s >= 0) cut_after(s);
      len = (s >= 0 && s < fin) ? s + 3 : fin + 2;
      for (int c = 1; c < len; c++) begin
        if ((eb[c] || ed[c]) && $urandom_range(0, 7) == 0) xs[c] = 1;
      end
      for (int c = 0; c < len; c++) begin
        start_i = (c == 0) || xs[c]; stop_i = (c == s);
        if (c > 0) begin
          last_idx_i = 2'($urandom_range(0, 3)); loop_i = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        n_cmp += 3;
        if (busy_o !== eb[c])  begin n_bad++; $display("FAIL rnd%0d busy c=%0d got %b want %b", it, c, busy_o, eb[c]); end
        if (pulse_o !== ep[c]) begin n_bad++; $display("FAIL rnd%0d pulse c=%0d got %b want %b", it, c, pulse_o, ep[c]); end
        if (done_o !== ed[c])  begin n_bad++; $display("FAIL rnd%0d done c=%0d got %b want %b", it, c, done_o, ed[c]); end
        if (eb[c]) begin
          n_cmp++;
          if (idx_o !== ei[c][1:0]) begin n_bad++; $display("FAIL rnd%0d idx c=%0d got %0d want %0d", it, c, idx_o, ei[c]); end
        end
        @(posedge clk); #1;
      end
      start_i = 1'b0; stop_i = 1'b0; loop_i = 1'b0;
    end
  endtask

  initial begin
    rst_i = 1'b1; wr_en_i = 1'b0; wr_addr_i = '0; wr_ticks_i = '0; wr_reps_i = '0;
    last_idx_i = '0; loop_i = 1'b0; start_i = 1'b0; stop_i = 1'b0;
    for (int a = 0; a < 4; a++) begin m_ticks[a] = 0; m_reps[a] = 0; end
    test_reset();
    test_single();
    test_two_entry();
    test_loop_stop();
    test_stop_restart();
    test_start_while_busy();
    test_write_during_load();
    test_reps0_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time budget (compared %0d)", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
